// File: rtl/gpr_pkg.sv
// Shared types and parameter-legality helper for the GPR file and its pointer unit.
package gpr_pkg;

    typedef enum logic [1:0] {
        PTR_X    = 2'd0,
        PTR_Y    = 2'd1,
        PTR_Z    = 2'd2,
        PTR_NONE = 2'd3
    } ptr_sel_t;

    typedef enum logic [1:0] {
        PTR_PLAIN   = 2'd0,
        PTR_POSTINC = 2'd1,
        PTR_PREDEC  = 2'd2,
        PTR_RSVD    = 2'd3
    } ptr_mode_t;

    localparam int GPR_PTR_BASE_DEF = 26;

    // X, Y and Z must fit as three consecutive register pairs inside the file.
    function automatic bit gpr_params_legal(input int w, input int n, input int base);
        return (w >= 4) && (n >= 2) && (n <= 32) && ((n % 2) == 0) &&
               (base >= 0) && ((base % 2) == 0) && (base + 5 < n);
    endfunction

endpackage

// File: rtl/gpr_file_param_if.sv
// Decoder-side bus of the GPR file: two read ports, byte/word write ports, pointer unit.
interface gpr_file_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 32
);
    localparam int AW = $clog2(REG_COUNT);
    localparam int PW = 2 * DATA_WIDTH;

    logic [AW-1:0]         rd_addr_a;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [AW-1:0]         rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_b;

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  wrw_en;
    logic [AW-1:0]         wrw_addr;
    logic [PW-1:0]         wrw_data;

    logic [1:0]            ptr_sel;
    logic [1:0]            ptr_mode;
    logic [5:0]            ptr_disp;
    logic [PW-1:0]         ptr_addr;

    modport master (
        output rd_addr_a, rd_addr_b,
        output wr_en, wr_addr, wr_data,
        output wrw_en, wrw_addr, wrw_data,
        output ptr_sel, ptr_mode, ptr_disp,
        input  rd_data_a, rd_data_b, ptr_addr
    );

    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  wr_en, wr_addr, wr_data,
        input  wrw_en, wrw_addr, wrw_data,
        input  ptr_sel, ptr_mode, ptr_disp,
        output rd_data_a, rd_data_b, ptr_addr
    );

endinterface

// File: rtl/gpr_ptr_unit.sv
// Combinational X/Y/Z pointer arithmetic: effective address, next pointer, update enable.
module gpr_ptr_unit
    import gpr_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      active,
    input  ptr_mode_t                 mode,
    input  logic [2*DATA_WIDTH-1:0]   ptr,
    input  logic [5:0]                disp,
    output logic [2*DATA_WIDTH-1:0]   addr,
    output logic [2*DATA_WIDTH-1:0]   ptr_nxt,
    output logic                      upd_en
);
    localparam int PW = 2 * DATA_WIDTH;

    // All arithmetic wraps modulo 2^PW by truncation to PW bits.
    always_comb begin
        addr    = '0;
        ptr_nxt = ptr;
        upd_en  = 1'b0;
        if (active) begin
            case (mode)
                PTR_POSTINC: begin
                    addr    = ptr;
                    ptr_nxt = ptr + PW'(1);
                    upd_en  = 1'b1;
                end
                PTR_PREDEC: begin
                    addr    = ptr - PW'(1);
                    ptr_nxt = ptr - PW'(1);
                    upd_en  = 1'b1;
                end
                default: addr = ptr + PW'(disp);
            endcase
        end
    end

endmodule

// File: rtl/gpr_file_param.sv
// Parametrised ATmega32A general-purpose register file with X/Y/Z pointer unit.
// Optional GPR_WRITE_BYPASS_EN: same-cycle write data is forwarded to reads and ptr_addr.
module gpr_file_param
    import gpr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 32,
    parameter int PTR_BASE   = GPR_PTR_BASE_DEF
) (
    input  logic              clock,
    input  logic              reset,
    gpr_file_param_if.slave   bus
);
    localparam int AW = $clog2(REG_COUNT);
    localparam int PW = 2 * DATA_WIDTH;

    if (!gpr_params_legal(DATA_WIDTH, REG_COUNT, PTR_BASE)) begin : g_bad_params
        $error("gpr_file_param: illegal DATA_WIDTH/REG_COUNT/PTR_BASE combination");
    end

    logic [DATA_WIDTH-1:0] regs     [REG_COUNT];
    logic [DATA_WIDTH-1:0] reg_nxt  [REG_COUNT];
    logic [DATA_WIDTH-1:0] rd_src   [REG_COUNT];
    logic [DATA_WIDTH-1:0] ptr_src  [REG_COUNT];

    logic [AW-1:0]   wrw_even;
    logic [AW-1:0]   wrw_odd;
    int              ptr_lo_idx;
    logic            ptr_active;
    logic [PW-1:0]   ptr_cur;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   ptr_addr_w;
    logic            ptr_upd;

    assign wrw_even   = {bus.wrw_addr[AW-1:1], 1'b0};
    assign wrw_odd    = {bus.wrw_addr[AW-1:1], 1'b1};
    assign ptr_active = (ptr_sel_t'(bus.ptr_sel) != PTR_NONE);
    assign ptr_lo_idx = PTR_BASE + 2 * int'(bus.ptr_sel);

`ifdef GPR_WRITE_BYPASS_EN
    // Byte/word writes only; the pointer's own update never feeds back into ptr_addr.
    logic [DATA_WIDTH-1:0] wr_view [REG_COUNT];

    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            wr_view[i] = regs[i];
            if (bus.wrw_en && wrw_even == AW'(i)) wr_view[i] = bus.wrw_data[DATA_WIDTH-1:0];
            if (bus.wrw_en && wrw_odd  == AW'(i)) wr_view[i] = bus.wrw_data[PW-1:DATA_WIDTH];
            if (bus.wr_en  && bus.wr_addr == AW'(i)) wr_view[i] = bus.wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            rd_src[i]  = reg_nxt[i];
            ptr_src[i] = wr_view[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            rd_src[i]  = regs[i];
            ptr_src[i] = regs[i];
        end
    end
`endif

    always_comb begin
        ptr_cur = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (i == ptr_lo_idx)     ptr_cur[DATA_WIDTH-1:0]  = ptr_src[i];
            if (i == ptr_lo_idx + 1) ptr_cur[PW-1:DATA_WIDTH] = ptr_src[i];
        end
    end

    gpr_ptr_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ptr (
        .active  (ptr_active),
        .mode    (ptr_mode_t'(bus.ptr_mode)),
        .ptr     (ptr_cur),
        .disp    (bus.ptr_disp),
        .addr    (ptr_addr_w),
        .ptr_nxt (ptr_nxt),
        .upd_en  (ptr_upd)
    );

    assign bus.ptr_addr = ptr_addr_w;

    // Lowest priority first so later assignments win: pointer < word < byte.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            reg_nxt[i] = regs[i];
            if (ptr_upd && i == ptr_lo_idx)         reg_nxt[i] = ptr_nxt[DATA_WIDTH-1:0];
            if (ptr_upd && i == ptr_lo_idx + 1)     reg_nxt[i] = ptr_nxt[PW-1:DATA_WIDTH];
            if (bus.wrw_en && wrw_even == AW'(i))   reg_nxt[i] = bus.wrw_data[DATA_WIDTH-1:0];
            if (bus.wrw_en && wrw_odd  == AW'(i))   reg_nxt[i] = bus.wrw_data[PW-1:DATA_WIDTH];
            if (bus.wr_en  && bus.wr_addr == AW'(i)) reg_nxt[i] = bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < REG_COUNT; i++) begin
            if (reset) regs[i] <= '0;
            else       regs[i] <= reg_nxt[i];
        end
    end

    // Addresses at or above REG_COUNT match no register and therefore read 0.
    always_comb begin
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (bus.rd_addr_a == AW'(i)) bus.rd_data_a = rd_src[i];
            if (bus.rd_addr_b == AW'(i)) bus.rd_data_b = rd_src[i];
        end
    end

endmodule

// File: tb/tb_gpr_file_param.sv
// Directed self-checking bench for gpr_file_param (default build, optional bypass checks).
module tb_gpr_file_param;
    import gpr_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    gpr_file_param_if #(.DATA_WIDTH(8), .REG_COUNT(32)) bus ();

    gpr_file_param #(
        .DATA_WIDTH (8),
        .REG_COUNT  (32),
        .PTR_BASE   (26)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wrw_en   = 1'b0;
        bus.wrw_addr = '0;
        bus.wrw_data = '0;
        bus.ptr_sel  = 2'd3;
        bus.ptr_mode = 2'd0;
        bus.ptr_disp = '0;
    endtask

    task automatic wr_byte(input logic [4:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        idle();
    endtask

    task automatic wr_word(input logic [4:0] a, input logic [15:0] d);
        bus.wrw_en = 1'b1; bus.wrw_addr = a; bus.wrw_data = d;
        tick();
        idle();
    endtask

    task automatic read2(input string tag, input logic [4:0] a, input logic [4:0] b,
                         input logic [7:0] ea, input logic [7:0] eb);
        bus.rd_addr_a = a;
        bus.rd_addr_b = b;
        #1;
        check({tag, "_a"}, {8'h00, bus.rd_data_a}, {8'h00, ea});
        check({tag, "_b"}, {8'h00, bus.rd_data_b}, {8'h00, eb});
    endtask

    task automatic ptr_plain(input string tag, input logic [1:0] sel, input logic [5:0] q,
                             input logic [15:0] exp);
        bus.ptr_sel = sel; bus.ptr_mode = 2'd0; bus.ptr_disp = q;
        #1;
        check(tag, bus.ptr_addr, exp);
        idle();
    endtask

    initial begin
        idle();
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            read2("reset_read", 5'(i), 5'(31 - i), 8'h00, 8'h00);
        end
        ptr_plain("reset_ptr_x", 2'd0, 6'd0, 16'h0000);

        // Byte writes
        bus.rd_addr_a = 5'd5;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 8'hA5;
        #1;
`ifdef GPR_WRITE_BYPASS_EN
        check("bypass_r5", {8'h00, bus.rd_data_a}, 16'h00A5);
`else
        check("no_bypass_r5", {8'h00, bus.rd_data_a}, 16'h0000);
`endif
        tick();
        idle();
        wr_byte(5'd31, 8'h3C);
        read2("byte_wr", 5'd5, 5'd31, 8'hA5, 8'h3C);

        // Word writes, LSB of pair address ignored
        wr_word(5'd24, 16'h1234);
        read2("word_wr24", 5'd24, 5'd25, 8'h34, 8'h12);
        wr_word(5'd25, 16'hBEEF);
        read2("word_wr25", 5'd24, 5'd25, 8'hEF, 8'hBE);

        // X post-increment wrap and back-to-back increments
        wr_word(5'd26, 16'hFFFF);
        bus.ptr_sel = 2'd0; bus.ptr_mode = 2'd1;
        #1;
        check("postinc_addr0", bus.ptr_addr, 16'hFFFF);
        tick();
        check("postinc_addr1", bus.ptr_addr, 16'h0000);
        tick();
        check("postinc_addr2", bus.ptr_addr, 16'h0001);
        tick();
        idle();
        ptr_plain("postinc_after", 2'd0, 6'd0, 16'h0002);
        read2("postinc_x", 5'd26, 5'd27, 8'h02, 8'h00);

        // Z pre-decrement wrap
        wr_word(5'd30, 16'h0000);
        bus.ptr_sel = 2'd2; bus.ptr_mode = 2'd2;
        #1;
        check("predec_addr", bus.ptr_addr, 16'hFFFF);
        tick();
        idle();
        read2("predec_z", 5'd30, 5'd31, 8'hFF, 8'hFF);

        // Y plain with displacement, no update
        wr_word(5'd28, 16'h0100);
        bus.ptr_sel = 2'd1; bus.ptr_mode = 2'd0; bus.ptr_disp = 6'd63;
        #1;
        check("plain_disp", bus.ptr_addr, 16'h013F);
        tick();
        idle();
        read2("plain_y", 5'd28, 5'd29, 8'h00, 8'h01);
        // Reserved mode behaves as plain
        bus.ptr_sel = 2'd1; bus.ptr_mode = 2'd3; bus.ptr_disp = 6'd2;
        #1;
        check("rsvd_addr", bus.ptr_addr, 16'h0102);
        tick();
        idle();
        read2("rsvd_y", 5'd28, 5'd29, 8'h00, 8'h01);
        ptr_plain("ptr_none", 2'd3, 6'd5, 16'h0000);

        // Byte write beats pointer update on XL; XH takes the update
        wr_word(5'd26, 16'h00FF);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd26; bus.wr_data = 8'h77;
        bus.ptr_sel = 2'd0; bus.ptr_mode = 2'd1;
        tick();
        idle();
        read2("ld_x_plus", 5'd26, 5'd27, 8'h77, 8'h01);

        // Byte write beats word write on the same register
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 8'h11;
        bus.wrw_en = 1'b1; bus.wrw_addr = 5'd2; bus.wrw_data = 16'hAAAA;
        tick();
        idle();
        read2("byte_over_word", 5'd2, 5'd3, 8'h11, 8'hAA);

        // Reset overrides every write and pointer update
        wr_word(5'd30, 16'h1234);
        reset = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 8'h55;
        bus.ptr_sel = 2'd2; bus.ptr_mode = 2'd1;
        tick();
        reset = 1'b0;
        idle();
        read2("reset_r3_z", 5'd3, 5'd30, 8'h00, 8'h00);
        read2("reset_zh_r5", 5'd31, 5'd5, 8'h00, 8'h00);
        ptr_plain("reset_ptr_z", 2'd2, 6'd0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
